// File: rtl/ysyx_040750_axi_master.sv
// Single-outstanding AXI4-Lite initiator turning LSU load/store requests into AR/R or AW/W/B traffic.
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES.
module ysyx_040750_axi_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic                I_req_valid,
  output logic                O_req_ready,
  input  logic                I_req_wen,
  input  logic [ADDR_W-1:0]   I_req_addr,
  input  logic [DATA_W-1:0]   I_req_wdata,
  input  logic [DATA_W/8-1:0] I_req_wstrb,
  output logic                O_resp_valid,
  output logic [DATA_W-1:0]   O_resp_rdata,
  output logic                O_resp_err,
  output logic [ADDR_W-1:0]   O_araddr,
  output logic                O_arvalid,
  input  logic                I_arready,
  input  logic [DATA_W-1:0]   I_rdata,
  input  logic                I_rvalid,
  output logic                O_rready,
  output logic [ADDR_W-1:0]   O_awaddr,
  output logic                O_awvalid,
  input  logic                I_awready,
  output logic [DATA_W-1:0]   O_wdata,
  output logic [DATA_W/8-1:0] O_wstrb,
  output logic                O_wvalid,
  input  logic                I_wready,
  input  logic                I_bvalid,
  output logic                O_bready
);
  typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR, S_WR_RESP, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d, b_done_q, b_done_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  aw_hs, w_hs, progress, timeout_hit, timed_out;

  assign aw_hs = awvalid_q & I_awready;
  assign w_hs  = wvalid_q & I_wready;

`ifdef AXI_MASTER_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        err_q;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE)
      cnt_d = '0;
    else if (state_q != S_DONE)
      cnt_d = cnt_q + 32'd1;
  end

  assign timeout_hit = (state_q != S_IDLE) && (state_q != S_DONE) &&
                       (cnt_d == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timed_out;
    end
  end

  assign O_resp_err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign O_resp_err         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    b_done_d  = b_done_q;
    timed_out = 1'b0;
    case (state_q)
      S_IDLE: if (I_req_valid) begin
        addr_d    = I_req_addr;
        wdata_d   = I_req_wdata;
        wstrb_d   = I_req_wstrb;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        b_done_d  = 1'b0;
        state_d   = I_req_wen ? S_WR : S_RD_ADDR;
      end
      S_RD_ADDR: if (arvalid_q && I_arready) state_d = S_RD_DATA;
      S_RD_DATA: if (rready_q && I_rvalid) begin
        rdata_d = I_rdata;
        state_d = S_DONE;
      end
      S_WR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        // A B beat only counts once the W beat has gone; earlier bvalid is ignored.
        b_done_d  = b_done_q | (w_done_d & I_bvalid);
        if (aw_done_d && w_done_d) begin
          if (b_done_d) begin
            state_d = S_DONE;
            rdata_d = '0;
          end else begin
            state_d = S_WR_RESP;
          end
        end
      end
      S_WR_RESP: if (I_bvalid) begin
        state_d = S_DONE;
        rdata_d = '0;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Any handshake in the expiry cycle wins over the watchdog.
    progress = (state_d != state_q) || aw_hs || w_hs || (b_done_d != b_done_q);
    if (timeout_hit && !progress) begin
      state_d   = S_DONE;
      rdata_d   = '0;
      timed_out = 1'b1;
    end
  end

  assign arvalid_d    = (state_d == S_RD_ADDR);
  assign rready_d     = (state_d == S_RD_DATA);
  assign awvalid_d    = (state_d == S_WR) && !aw_done_d;
  assign wvalid_d     = (state_d == S_WR) && !w_done_d;
  assign bready_d     = (state_d == S_WR) || (state_d == S_WR_RESP);
  assign resp_valid_d = (state_d == S_DONE);

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      b_done_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      b_done_q     <= b_done_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign O_req_ready  = (state_q == S_IDLE);
  assign O_resp_valid = resp_valid_q;
  assign O_resp_rdata = rdata_q;
  assign O_araddr     = addr_q;
  assign O_arvalid    = arvalid_q;
  assign O_rready     = rready_q;
  assign O_awaddr     = addr_q;
  assign O_awvalid    = awvalid_q;
  assign O_wdata      = wdata_q;
  assign O_wstrb      = wstrb_q;
  assign O_wvalid     = wvalid_q;
  assign O_bready     = bready_q;
endmodule

// File: tb/tb_ysyx_040750_axi_master.sv
// Self-checking bench for ysyx_040750_axi_master: directed table, reset abort, optional watchdog, random traffic.
module tb_ysyx_040750_axi_master;
  localparam int TB_TIMEOUT = 16;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_req_valid, I_req_wen;
  logic [31:0] I_req_addr;
  logic [63:0] I_req_wdata;
  logic [7:0]  I_req_wstrb;
  logic        O_req_ready, O_resp_valid, O_resp_err;
  logic [63:0] O_resp_rdata;
  logic [31:0] O_araddr, O_awaddr;
  logic        O_arvalid, I_arready, I_rvalid, O_rready;
  logic [63:0] I_rdata, O_wdata;
  logic        O_awvalid, I_awready, O_wvalid, I_wready, I_bvalid, O_bready;
  logic [7:0]  O_wstrb;

  always #5 I_clk = ~I_clk;

  ysyx_040750_axi_master #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_req_valid(I_req_valid), .O_req_ready(O_req_ready), .I_req_wen(I_req_wen),
    .I_req_addr(I_req_addr), .I_req_wdata(I_req_wdata), .I_req_wstrb(I_req_wstrb),
    .O_resp_valid(O_resp_valid), .O_resp_rdata(O_resp_rdata), .O_resp_err(O_resp_err),
    .O_araddr(O_araddr), .O_arvalid(O_arvalid), .I_arready(I_arready),
    .I_rdata(I_rdata), .I_rvalid(I_rvalid), .O_rready(O_rready),
    .O_awaddr(O_awaddr), .O_awvalid(O_awvalid), .I_awready(I_awready),
    .O_wdata(O_wdata), .O_wstrb(O_wstrb), .O_wvalid(O_wvalid), .I_wready(I_wready),
    .I_bvalid(I_bvalid), .O_bready(O_bready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata;
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    logic        busy_req;
    int          exp_lat;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t tbl[6];

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mkvec(input logic wen, input logic [31:0] addr, input logic [63:0] wdata,
                                 input logic [7:0] wstrb, input logic [63:0] rdata,
                                 input int ar, input int r, input int aw, input int w, input int b,
                                 input logic busy, input int lat, input logic [63:0] erd);
    vec_t v;
    v.wen = wen; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.rdata = rdata;
    v.ar_dly = ar; v.r_dly = r; v.aw_dly = aw; v.w_dly = w; v.b_dly = b;
    v.busy_req = busy; v.exp_lat = lat; v.exp_rdata = erd;
    return v;
  endfunction

  // Reference latency: accept is cycle 0; completion pulse is the cycle after the last needed beat.
  function automatic int model_lat(input vec_t v);
    int aw_c, w_c;
    if (!v.wen) return 1 + v.ar_dly + v.r_dly + 1;
    if (v.b_dly < 0) return TB_TIMEOUT + 1;
    aw_c = 1 + v.aw_dly;
    w_c  = 1 + v.w_dly;
    return ((aw_c > w_c) ? aw_c : w_c) + v.b_dly + 1;
  endfunction

  task automatic quiet_responder();
    I_arready = 1'b0; I_rvalid = 1'b0; I_rdata = '0;
    I_awready = 1'b0; I_wready = 1'b0; I_bvalid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk64({tag, " ctrl"}, 64'({O_arvalid, O_rready, O_awvalid, O_wvalid, O_bready, O_resp_valid, O_resp_err}), 64'd0);
    chk64({tag, " addr"}, {O_araddr, O_awaddr}, 64'd0);
    chk64({tag, " wdata"}, O_wdata, 64'd0);
    chk64({tag, " wstrb"}, 64'(O_wstrb), 64'd0);
    chk64({tag, " rdata"}, O_resp_rdata, 64'd0);
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge after the completion cycle.
  task automatic run_txn(input int id, input vec_t v, input int abort_at);
    int ar_cnt, aw_cnt, w_cnt, ar_hs_c, aw_hs_c, w_hs_c, n_ar, n_aw, n_w, n_r, n_b, pulse_c;
    logic [63:0] got_rdata;
    logic        got_err;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; ar_hs_c = -1; aw_hs_c = -1; w_hs_c = -1;
    n_ar = 0; n_aw = 0; n_w = 0; n_r = 0; n_b = 0; pulse_c = -1;
    got_rdata = '0; got_err = 1'b0;
    chk64($sformatf("txn%0d req_ready_idle", id), 64'(O_req_ready), 64'd1);
    I_req_valid = 1'b1; I_req_wen = v.wen; I_req_addr = v.addr;
    I_req_wdata = v.wdata; I_req_wstrb = v.wstrb;
    @(negedge I_clk);
    if (v.busy_req) begin
      I_req_wen  = 1'b0;
      I_req_addr = v.addr ^ 32'h0000_1000;
    end else begin
      I_req_valid = 1'b0;
    end
    for (int c = 1; c <= 200; c++) begin
      if (O_resp_valid) begin
        pulse_c = c; got_rdata = O_resp_rdata; got_err = O_resp_err;
        break;
      end
      chk64($sformatf("txn%0d req_ready_busy", id), 64'(O_req_ready), 64'd0);
      if (O_arvalid) chk64($sformatf("txn%0d araddr", id), 64'(O_araddr), 64'(v.addr));
      if (O_awvalid) chk64($sformatf("txn%0d awaddr", id), 64'(O_awaddr), 64'(v.addr));
      if (O_wvalid) begin
        chk64($sformatf("txn%0d wdata", id), O_wdata, v.wdata);
        chk64($sformatf("txn%0d wstrb", id), 64'(O_wstrb), 64'(v.wstrb));
      end
      if (w_hs_c >= 0) chk64($sformatf("txn%0d wvalid_dropped", id), 64'(O_wvalid), 64'd0);
      if (aw_hs_c >= 0) chk64($sformatf("txn%0d awvalid_dropped", id), 64'(O_awvalid), 64'd0);
      if (c == abort_at) begin
        #2 I_rst = 1'b1;
        #1 check_all_zero($sformatf("txn%0d async_rst", id));
        quiet_responder();
        I_req_valid = 1'b0;
        @(negedge I_clk);
        I_rst = 1'b0;
        repeat (3) begin
          @(negedge I_clk);
          chk64($sformatf("txn%0d post_rst_resp_valid", id), 64'(O_resp_valid), 64'd0);
          chk64($sformatf("txn%0d post_rst_arvalid", id), 64'(O_arvalid), 64'd0);
          chk64($sformatf("txn%0d post_rst_req_ready", id), 64'(O_req_ready), 64'd1);
        end
        return;
      end
      I_arready = O_arvalid && (ar_cnt >= v.ar_dly);
      if (O_arvalid) ar_cnt++;
      if (O_arvalid && I_arready) begin n_ar++; ar_hs_c = c; end
      I_rvalid = (ar_hs_c >= 0) && (c >= ar_hs_c + v.r_dly) && (n_r == 0);
      I_rdata  = I_rvalid ? v.rdata : 64'd0;
      if (I_rvalid && O_rready) n_r++;
      I_awready = O_awvalid && (aw_cnt >= v.aw_dly);
      if (O_awvalid) aw_cnt++;
      if (O_awvalid && I_awready) begin n_aw++; aw_hs_c = c; end
      I_wready = O_wvalid && (w_cnt >= v.w_dly);
      if (O_wvalid) w_cnt++;
      if (O_wvalid && I_wready) begin n_w++; w_hs_c = c; end
      I_bvalid = (aw_hs_c >= 0) && (w_hs_c >= 0) && (v.b_dly >= 0) && (n_b == 0) &&
                 (c >= ((aw_hs_c > w_hs_c) ? aw_hs_c : w_hs_c) + v.b_dly);
      if (I_bvalid && O_bready) n_b++;
      @(negedge I_clk);
    end
    quiet_responder();
    chk_int($sformatf("txn%0d latency", id), pulse_c, v.exp_lat);
    if (pulse_c >= 0) begin
      chk64($sformatf("txn%0d resp_rdata", id), got_rdata, v.exp_rdata);
      chk64($sformatf("txn%0d resp_err", id), 64'(got_err), 64'(v.wen && v.b_dly < 0));
      chk_int($sformatf("txn%0d ar_beats", id), n_ar, v.wen ? 0 : 1);
      chk_int($sformatf("txn%0d aw_beats", id), n_aw, v.wen ? 1 : 0);
      chk_int($sformatf("txn%0d w_beats", id), n_w, v.wen ? 1 : 0);
      @(negedge I_clk);
      I_req_valid = 1'b0;
      chk64($sformatf("txn%0d pulse_one_cycle", id), 64'(O_resp_valid), 64'd0);
      chk64($sformatf("txn%0d req_ready_after", id), 64'(O_req_ready), 64'd1);
      chk64($sformatf("txn%0d rdata_held", id), O_resp_rdata, v.exp_rdata);
    end else begin
      I_req_valid = 1'b0;
      I_rst = 1'b1;
      @(negedge I_clk);
      I_rst = 1'b0;
    end
  endtask

  initial begin
    vec_t v;
    I_rst = 1'b1;
    I_req_valid = 1'b0; I_req_wen = 1'b0; I_req_addr = '0; I_req_wdata = '0; I_req_wstrb = '0;
    quiet_responder();
    repeat (2) @(negedge I_clk);
    check_all_zero("reset");
    I_rst = 1'b0;
    @(negedge I_clk);
    chk64("req_ready_after_rst", 64'(O_req_ready), 64'd1);

    tbl[0] = mkvec(1'b0, 32'h0200_BFF8, 64'd0, 8'h00, 64'h0000_0000_0000_1234,
                   0, 1, 0, 0, 0, 1'b0, 3, 64'h1234);
    tbl[1] = mkvec(1'b1, 32'h0200_4000, 64'hFFFF_0000_AAAA_5555, 8'h0F, 64'd0,
                   0, 1, 0, 0, 0, 1'b0, 2, 64'd0);
    tbl[2] = mkvec(1'b1, 32'h1000_0008, 64'h0123_4567_89AB_CDEF, 8'hF0, 64'd0,
                   0, 1, 3, 0, 2, 1'b0, 7, 64'd0);
    tbl[3] = mkvec(1'b0, 32'h8000_0100, 64'd0, 8'h00, 64'hDEAD_BEEF_0BAD_F00D,
                   5, 1, 0, 0, 0, 1'b1, 8, 64'hDEAD_BEEF_0BAD_F00D);
    tbl[4] = mkvec(1'b0, 32'h8000_0108, 64'd0, 8'h00, 64'hCAFE_0000_0000_0001,
                   0, 2, 0, 0, 0, 1'b0, 4, 64'hCAFE_0000_0000_0001);
    tbl[5] = mkvec(1'b1, 32'h8000_0200, 64'h5A5A_5A5A_A5A5_A5A5, 8'hFF, 64'd0,
                   0, 1, 0, 2, 1, 1'b0, 5, 64'd0);
    for (int i = 0; i < 6; i++) run_txn(i, tbl[i], -1);

    v = mkvec(1'b0, 32'h8000_0300, 64'd0, 8'h00, 64'h1111_2222_3333_4444,
              0, 4, 0, 0, 0, 1'b0, 6, 64'h1111_2222_3333_4444);
    run_txn(10, v, 3);
    v = mkvec(1'b0, 32'h8000_0308, 64'd0, 8'h00, 64'h5555_6666_7777_8888,
              0, 1, 0, 0, 0, 1'b0, 3, 64'h5555_6666_7777_8888);
    run_txn(11, v, -1);

`ifdef AXI_MASTER_TIMEOUT_EN
    v = mkvec(1'b1, 32'h0200_4008, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, 64'd0,
              0, 1, 0, 0, -1, 1'b0, TB_TIMEOUT + 1, 64'd0);
    run_txn(20, v, -1);
`endif

    for (int i = 0; i < 40; i++) begin
      v = mkvec(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                {$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 3) == 0), 0, 64'd0);
      v.exp_lat   = model_lat(v);
      v.exp_rdata = v.wen ? 64'd0 : v.rdata;
      run_txn(100 + i, v, -1);
    end

    I_req_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
